// File: rtl/daq_seq_pkg.sv
// Shared types and word layouts for the AMC13 event sequencer.
// Header/trailer field offsets live here so builder and checker agree.
package daq_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        CHAN,
        TRAILER
    } state_t;

    localparam logic [7:0] HDR_TYPE = 8'h08;

    localparam int HDR_TYPE_LSB = 56;
    localparam int HDR_EVT_LSB  = 32;

    localparam int TRL_EVT_LSB  = 28;
    localparam int TRL_ERR_LSB  = 20;
    localparam int TRL_WC_LSB   = 0;

    function automatic logic [63:0] make_header(
        input logic [23:0] evt
    );
        logic [63:0] w;
        w = '0;
        w[HDR_TYPE_LSB +: 8] = HDR_TYPE;
        w[HDR_EVT_LSB +: 24] = evt;
        return w;
    endfunction

    function automatic logic [63:0] make_trailer(
        input logic [7:0]  evt,
        input logic [4:0]  err,
        input logic [19:0] wc
    );
        logic [63:0] w;
        w = '0;
        w[TRL_EVT_LSB +: 8] = evt;
        w[TRL_ERR_LSB +: 5] = err;
        w[TRL_WC_LSB +: 20] = wc;
        return w;
    endfunction

endpackage

// File: rtl/daq_trig_queue.sv
// Pending-trigger counter: saturating up/down with a sticky
// overflow flag for triggers dropped at saturation.
module daq_trig_queue #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         overflow
);

    localparam logic [W-1:0] MAX = '1;

    // Count triggers in, events out; simultaneous inc/dec cancel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc && !dec) begin
            if (count == MAX) overflow <= 1'b1;
            else              count    <= count + 1'b1;
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/daq_event_sequencer.sv
// Builds one AMC13 event per queued trigger: header, enabled
// channel blocks in ascending order, trailer, onto DAQ_Link_7S.
module daq_event_sequencer
    import daq_seq_pkg::*;
#(
    parameter int NUM_CHAN = 5,
    parameter int TRIG_Q_W = 8,
    parameter int TIMEOUT  = 4096
) (
    input  logic                    clk125,
    input  logic                    rst_n,
    input  logic                    trigger,
    input  logic [NUM_CHAN-1:0]     chan_en,
    input  logic [NUM_CHAN-1:0]     chan_valid,
    input  logic [64*NUM_CHAN-1:0]  chan_data,
    input  logic [NUM_CHAN-1:0]     chan_last,
    output logic [NUM_CHAN-1:0]     chan_ready,
    input  logic                    daq_ready,
    input  logic                    daq_almost_full,
    output logic                    daq_valid,
    output logic                    daq_header,
    output logic                    daq_trailer,
    output logic [63:0]             daq_data,
    output logic [23:0]             evt_num,
    output logic                    trig_overflow,
    output logic                    busy
);

    localparam int CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t state, state_next;

    logic [NUM_CHAN-1:0] mask;
    logic [NUM_CHAN-1:0] err;
    logic [CH_W-1:0]     ch;
    logic [CH_W-1:0]     first_ch;
    logic [CH_W-1:0]     next_ch;
    logic                first_found;
    logic                next_found;
    logic [19:0]         word_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [TRIG_Q_W-1:0] q_count;

    logic        stall;
    logic        sel_valid;
    logic        sel_last;
    logic [63:0] sel_data;
    logic        hdr_beat;
    logic        chan_beat;
    logic        trl_beat;
    logic        tmo_hit;
    logic        chan_done;
    logic        leave_idle;

    assign stall     = daq_almost_full | ~daq_ready;
    assign sel_valid = chan_valid[ch];
    assign sel_last  = chan_last[ch];
    assign sel_data  = chan_data[64*ch +: 64];

    assign tmo_hit   = (state == CHAN) && !sel_valid && !stall
                     && (tmo_cnt == TMO_LAST);
    assign chan_done = (chan_beat && sel_last) || tmo_hit;

    daq_trig_queue #(
        .W (TRIG_Q_W)
    ) u_queue (
        .clk      (clk125),
        .rst_n    (rst_n),
        .inc      (trigger),
        .dec      (leave_idle),
        .count    (q_count),
        .overflow (trig_overflow)
    );

    // Lowest enabled channel, and next mask bit above the current one
    always_comb begin
        first_found = 1'b0;
        first_ch    = '0;
        next_found  = 1'b0;
        next_ch     = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (chan_en[i]) begin
                first_found = 1'b1;
                first_ch    = CH_W'(i);
            end
            if (mask[i] && (i > int'(ch))) begin
                next_found = 1'b1;
                next_ch    = CH_W'(i);
            end
        end
    end

    // State register
    always_ff @(posedge clk125) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; every beat-issuing state holds under stall
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (q_count != '0 && !stall) state_next = HEADER;
            end
            HEADER: begin
                if (!stall) state_next = first_found ? CHAN : TRAILER;
            end
            CHAN: begin
                if (chan_done && !next_found) state_next = TRAILER;
            end
            TRAILER: begin
                if (!stall) state_next = IDLE;
            end
        endcase
    end

    // Per-state strobes and the channel accept
    always_comb begin
        busy       = (state != IDLE);
        leave_idle = (state == IDLE) && (state_next == HEADER);
        hdr_beat   = (state == HEADER) && !stall;
        chan_beat  = (state == CHAN) && sel_valid && !stall;
        trl_beat   = (state == TRAILER) && !stall;
        chan_ready = '0;
        if (state == CHAN && !stall) chan_ready[ch] = 1'b1;
    end

    // Registered event port and per-event bookkeeping
    always_ff @(posedge clk125) begin
        if (!rst_n) begin
            daq_valid   <= 1'b0;
            daq_header  <= 1'b0;
            daq_trailer <= 1'b0;
            daq_data    <= '0;
            evt_num     <= '0;
            mask        <= '0;
            err         <= '0;
            ch          <= '0;
            word_cnt    <= '0;
            tmo_cnt     <= '0;
        end else begin
            daq_valid   <= hdr_beat | chan_beat | trl_beat;
            daq_header  <= hdr_beat;
            daq_trailer <= trl_beat;
            if (hdr_beat) begin
                daq_data <= make_header(evt_num + 24'd1);
                mask     <= chan_en;
                err      <= '0;
                ch       <= first_ch;
                word_cnt <= 20'd1;
                tmo_cnt  <= '0;
            end
            if (chan_beat) begin
                daq_data <= sel_data;
                word_cnt <= word_cnt + 20'd1;
            end
            if (state == CHAN) begin
                if (chan_done) begin
                    if (tmo_hit) err[ch] <= 1'b1;
                    if (next_found) ch <= next_ch;
                    tmo_cnt <= '0;
                end else if (chan_beat) begin
                    tmo_cnt <= '0;
                end else if (!stall) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
            if (trl_beat) begin
                daq_data <= make_trailer(evt_num[7:0] + 8'd1,
                                         5'(err),
                                         word_cnt + 20'd1);
                evt_num  <= evt_num + 24'd1;
            end
        end
    end

endmodule

// File: tb/tb_daq_event_sequencer.sv
// Directed bench for daq_event_sequencer: a per-cycle vector
// table plus hand sequences for stall, timeout, overflow, reset.
module tb_daq_event_sequencer;

    localparam int NC  = 5;
    localparam int TMO = 4096;

    logic            clk125 = 1'b0;
    logic            rst_n;
    logic            trigger;
    logic [NC-1:0]   chan_en;
    logic [NC-1:0]   chan_valid;
    logic [64*NC-1:0] chan_data;
    logic [NC-1:0]   chan_last;
    logic [NC-1:0]   chan_ready;
    logic            daq_ready;
    logic            daq_almost_full;
    logic            daq_valid;
    logic            daq_header;
    logic            daq_trailer;
    logic [63:0]     daq_data;
    logic [23:0]     evt_num;
    logic            trig_overflow;
    logic            busy;

    int n_vec = 0;
    int n_err = 0;

    daq_event_sequencer #(
        .NUM_CHAN (NC),
        .TRIG_Q_W (8),
        .TIMEOUT  (TMO)
    ) dut (
        .clk125          (clk125),
        .rst_n           (rst_n),
        .trigger         (trigger),
        .chan_en         (chan_en),
        .chan_valid      (chan_valid),
        .chan_data       (chan_data),
        .chan_last       (chan_last),
        .chan_ready      (chan_ready),
        .daq_ready       (daq_ready),
        .daq_almost_full (daq_almost_full),
        .daq_valid       (daq_valid),
        .daq_header      (daq_header),
        .daq_trailer     (daq_trailer),
        .daq_data        (daq_data),
        .evt_num         (evt_num),
        .trig_overflow   (trig_overflow),
        .busy            (busy)
    );

    always #5 clk125 = ~clk125;

    typedef struct {
        logic          trig;
        logic [NC-1:0] en;
        logic [NC-1:0] vld;
        logic [NC-1:0] lst;
        logic [63:0]   d;
        logic          ev;
        logic          eh;
        logic          et;
        logic [63:0]   edata;
        logic [NC-1:0] erdy;
        logic          ebusy;
        logic [23:0]   eevt;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mkv(
        input logic trig, input logic [4:0] en,
        input logic [4:0] vld, input logic [4:0] lst,
        input logic [63:0] d, input logic ev,
        input logic eh, input logic et,
        input logic [63:0] ed, input logic [4:0] er,
        input logic eb, input logic [23:0] ee
    );
        vec_t v;
        v.trig = trig; v.en = en; v.vld = vld; v.lst = lst;
        v.d = d; v.ev = ev; v.eh = eh; v.et = et;
        v.edata = ed; v.erdy = er; v.ebusy = eb; v.eevt = ee;
        return v;
    endfunction

    task automatic step();
        @(posedge clk125);
        #1;
    endtask

    task automatic drive_data(input logic [63:0] d);
        for (int i = 0; i < NC; i++)
            chan_data[64*i +: 64] = d + 64'(i);
    endtask

    task automatic chk(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic wait_beat(input string nm, input bit trl,
                             input int budget);
        int n;
        n = 0;
        while (!(daq_valid && (trl ? daq_trailer : daq_header))
               && n < budget) begin
            step();
            n++;
        end
        n_vec++;
        if (!(daq_valid && (trl ? daq_trailer : daq_header))) begin
            n_err++;
            $display("FAIL %s: no beat within %0d cycles", nm, budget);
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
    endtask

    initial begin
        int k, j, n, cnt;
        logic hs, af_prev, ok;

        rst_n = 1'b0; trigger = 1'b0; chan_en = '0;
        chan_valid = '0; chan_last = '0; chan_data = '0;
        daq_ready = 1'b1; daq_almost_full = 1'b0;

        // event 1: ch0 three words, ch2 one word
        tbl[0]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[2]  = mkv(0, 5'b00101, 5'b00001, 0, 64'hA0, 1, 1, 0,
                      64'h0800_0001_0000_0000, 5'b00001, 1, 0);
        tbl[3]  = mkv(0, 5'b00101, 5'b00001, 0, 64'hA0, 1, 0, 0,
                      64'hA0, 5'b00001, 1, 0);
        tbl[4]  = mkv(0, 5'b00101, 5'b00001, 0, 64'hA1, 1, 0, 0,
                      64'hA1, 5'b00001, 1, 0);
        tbl[5]  = mkv(0, 5'b00101, 5'b00001, 5'b00001, 64'hA2,
                      1, 0, 0, 64'hA2, 5'b00100, 1, 0);
        tbl[6]  = mkv(0, 5'b00101, 5'b00100, 5'b00100, 64'hB0,
                      1, 0, 0, 64'hB2, 0, 1, 0);
        tbl[7]  = mkv(0, 0, 0, 0, 0, 1, 0, 1,
                      64'h0000_0000_1000_0006, 0, 0, 1);
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // event 2: no channels enabled
        tbl[9]  = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tbl[11] = mkv(0, 0, 0, 0, 0, 1, 1, 0,
                      64'h0800_0002_0000_0000, 0, 1, 1);
        tbl[12] = mkv(0, 0, 0, 0, 0, 1, 0, 1,
                      64'h0000_0000_2000_0002, 0, 0, 2);
        tbl[13] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        // trigger coincides with leaving IDLE: queue stays at 1
        tbl[14] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        tbl[15] = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        tbl[16] = mkv(0, 0, 0, 0, 0, 1, 1, 0,
                      64'h0800_0003_0000_0000, 0, 1, 2);
        tbl[17] = mkv(0, 0, 0, 0, 0, 1, 0, 1,
                      64'h0000_0000_3000_0002, 0, 0, 3);
        tbl[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        tbl[19] = mkv(0, 0, 0, 0, 0, 1, 1, 0,
                      64'h0800_0004_0000_0000, 0, 1, 3);
        tbl[20] = mkv(0, 0, 0, 0, 0, 1, 0, 1,
                      64'h0000_0000_4000_0002, 0, 0, 4);
        tbl[21] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4);

        repeat (3) step();
        rst_n = 1'b1;
        chk("reset_outputs",
            {daq_valid, daq_header, daq_trailer, trig_overflow,
             busy, 3'b0, chan_ready, evt_num},
            '0);
        chk("reset_data", daq_data, 64'h0);

        for (int i = 0; i < 22; i++) begin
            trigger    = tbl[i].trig;
            chan_en    = tbl[i].en;
            chan_valid = tbl[i].vld;
            chan_last  = tbl[i].lst;
            drive_data(tbl[i].d);
            step();
            ok = (daq_valid === tbl[i].ev)
              && (daq_header === tbl[i].eh)
              && (daq_trailer === tbl[i].et)
              && (chan_ready === tbl[i].erdy)
              && (busy === tbl[i].ebusy)
              && (evt_num === tbl[i].eevt)
              && (!tbl[i].ev || daq_data === tbl[i].edata);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL vec%0d: got v%b h%b t%b d=%h rdy=%b busy=%b evt=%0d expected v%b h%b t%b d=%h rdy=%b busy=%b evt=%0d",
                    i, daq_valid, daq_header, daq_trailer, daq_data,
                    chan_ready, busy, evt_num, tbl[i].ev, tbl[i].eh,
                    tbl[i].et, tbl[i].edata, tbl[i].erdy,
                    tbl[i].ebusy, tbl[i].eevt);
            end
        end
        trigger = 0; chan_en = 0; chan_valid = 0; chan_last = 0;

        // AlmostFull held 10 cycles in the middle of a channel block
        chan_en = 5'b00001;
        pulse_trigger();
        wait_beat("stall_hdr", 1'b0, 10);
        chk("stall_hdr_data", daq_data, 64'h0800_0005_0000_0000);
        k = 0; j = 0; n = 0; af_prev = 1'b0;
        while (k < 6 && n < 40) begin
            daq_almost_full = (n >= 2 && n < 12);
            chan_valid = 5'b00001;
            chan_data[63:0] = 64'hC0 + 64'(k);
            chan_last = (k == 5) ? 5'b00001 : 5'b00000;
            #1;
            hs = chan_ready[0];
            if (daq_almost_full) chk("stall_ready", chan_ready, 0);
            else chk("run_ready", chan_ready, 5'b00001);
            af_prev = daq_almost_full;
            step();
            if (hs) k++;
            if (af_prev) chk("stall_valid", daq_valid, 0);
            if (daq_valid) begin
                chk("stall_word", daq_data, 64'hC0 + 64'(j));
                j++;
            end
            n++;
        end
        daq_almost_full = 0; chan_valid = 0; chan_last = 0;
        chk("stall_words", 64'(j), 64'd6);
        wait_beat("stall_trl", 1'b1, 5);
        chk("stall_trl_data", daq_data, 64'h0000_0000_5000_0008);
        step();
        chk("stall_evt", 64'(evt_num), 64'd5);

        // channel 1 enabled but silent: abandoned after TIMEOUT
        chan_en = 5'b00010;
        pulse_trigger();
        wait_beat("tmo_hdr", 1'b0, 10);
        n = 0;
        while (!(daq_valid && daq_trailer) && n < TMO + 20) begin
            step();
            n++;
        end
        n_vec++;
        if (n < TMO || n > TMO + 2) begin
            n_err++;
            $display("FAIL tmo_latency: got %0d cycles expected %0d..%0d",
                     n, TMO, TMO + 2);
        end
        chk("tmo_trl_data", daq_data, 64'h0000_0000_6020_0002);
        step();
        chan_en = 0;

        // 255 triggers fill the queue while stalled, one more overflows
        daq_ready = 1'b0;
        trigger = 1'b1;
        repeat (255) step();
        trigger = 1'b0;
        step();
        chk("ovf_not_yet", {busy, trig_overflow}, 2'b00);
        pulse_trigger();
        step();
        chk("ovf_set", trig_overflow, 1);
        daq_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 255 * 3 + 30; c++) begin
            step();
            if (daq_valid && daq_trailer) cnt++;
        end
        chk("ovf_events", 64'(cnt), 64'd255);
        chk("ovf_evt_num", 64'(evt_num), 64'd261);
        chk("ovf_idle", {busy, trig_overflow}, 2'b01);

        // reset in the middle of a channel block
        chan_en = 5'b00001;
        pulse_trigger();
        wait_beat("rst_hdr", 1'b0, 10);
        chan_valid = 5'b00001;
        chan_data[63:0] = 64'hD0;
        step();
        chk("rst_pre_beat", daq_data, 64'hD0);
        rst_n = 1'b0;
        step();
        chk("rst_outputs",
            {daq_valid, daq_header, daq_trailer, trig_overflow,
             busy, 3'b0, chan_ready, evt_num},
            '0);
        chk("rst_data", daq_data, 64'h0);
        rst_n = 1'b1;
        chan_valid = 0;
        chan_en = 0;
        step();
        pulse_trigger();
        wait_beat("post_rst_hdr", 1'b0, 10);
        chk("post_rst_hdr_data", daq_data, 64'h0800_0001_0000_0000);
        step();
        chk("post_rst_trl",
            {daq_valid, daq_trailer, daq_data},
            {2'b11, 64'h0000_0000_1000_0002});
        chk("post_rst_evt", 64'(evt_num), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
